// File: rtl/rtc_calendar_edit.sv
// BCD time-of-day and Gregorian calendar with a push-button edit FSM, auto-repeat and blink strobe.
// Optional 12-hour outputs (hour12, pm) are built when TWELVE_HOUR_EN is defined.
module rtc_calendar_edit #(
  parameter int          TICK_DIV      = 50_000_000,
  parameter int          FAST_DIV      = 500,
  parameter int          REPEAT_DELAY  = 25_000_000,
  parameter int          REPEAT_PERIOD = 6_250_000,
  parameter int          BLINK_DIV     = 12_500_000,
  parameter logic [15:0] RESET_YEAR    = 16'h2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw_speed,
  input  logic        butt_change,
  input  logic        butt_increase,
  input  logic        butt_decrease,
  output logic [7:0]  hour,
  output logic [7:0]  min,
  output logic [7:0]  sec,
  output logic [7:0]  day,
  output logic [7:0]  month,
  output logic [15:0] year,
  output logic [2:0]  edit_field,
  output logic        blink,
  output logic        tick_out
`ifdef TWELVE_HOUR_EN
  ,
  output logic [7:0]  hour12,
  output logic        pm
`endif
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_SEC   = 3'd3,
    SET_DAY   = 3'd4,
    SET_MONTH = 3'd5,
    SET_YEAR  = 3'd6
  } state_t;

  localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
  localparam logic [31:0] FAST_LAST  = 32'(FAST_DIV - 1);
  localparam logic [31:0] DELAY_CNT  = 32'(REPEAT_DELAY);
  localparam logic [31:0] PERIOD_CNT = 32'(REPEAT_PERIOD);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);

  function automatic logic [7:0] bcd_up(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi);
    if (v >= hi)               return lo;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dn(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi);
    if (v <= lo)               return hi;
    else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    else                       return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [15:0] year_up(input logic [15:0] y);
    logic [15:0] r;
    logic        c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] year_dn(input logic [15:0] y);
    logic [15:0] r;
    logic        b;
    r = y;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Leap test straight from the BCD digits: low pair gives mod 4 / mod 100, high pair mod 400.
  function automatic logic is_leap(input logic [15:0] y);
    logic [6:0] lo2;
    logic [6:0] hi2;
    lo2 = 7'(y[7:4]) * 7'd10 + 7'(y[3:0]);
    hi2 = 7'(y[15:12]) * 7'd10 + 7'(y[11:8]);
    return ((lo2 % 7'd4) == 7'd0) && ((lo2 != 7'd0) || ((hi2 % 7'd4) == 7'd0));
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [15:0] y);
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  // Button front end: index 0 change (single shot), 1 increase, 2 decrease (auto-repeat).
  logic [2:0] raw;
  logic [2:0] pulse;
  logic [1:0] arm_q;

  assign raw = {butt_decrease, butt_increase, butt_change};

  // Synchroniser outputs are trusted only once they carry real samples, so a button
  // held through reset must be released before it can step anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) arm_q <= 2'b00;
    else        arm_q <= {arm_q[0], 1'b1};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      localparam bit REPEATS = (gi != 0);
      logic        sync_a;
      logic        sync_b;
      logic        armed;
      logic        rep_on;
      logic [31:0] rep_cnt;

      assign pulse[gi] = armed && !sync_b &&
                         ((rep_cnt == 32'd0) ||
                          (REPEATS && !rep_on && (rep_cnt == DELAY_CNT)) ||
                          (REPEATS && rep_on && (rep_cnt == PERIOD_CNT)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_a  <= 1'b1;
          sync_b  <= 1'b1;
          armed   <= 1'b0;
          rep_on  <= 1'b0;
          rep_cnt <= 32'd0;
        end else begin
          sync_a <= raw[gi];
          sync_b <= sync_a;
          if (arm_q[1] && sync_b) armed <= 1'b1;
          if (sync_b || !armed) begin
            rep_cnt <= 32'd0;
            rep_on  <= 1'b0;
          end else if (pulse[gi]) begin
            rep_cnt <= 32'd1;
            if (rep_cnt != 32'd0) rep_on <= 1'b1;
          end else if (REPEATS) begin
            rep_cnt <= rep_cnt + 32'd1;
          end
        end
      end
    end
  endgenerate

  logic chg_p, inc_p, dec_p;
  assign chg_p = pulse[0];
  assign inc_p = pulse[1];
  assign dec_p = pulse[2];

  state_t      state;
  logic [31:0] presc;
  logic [31:0] blink_cnt;
  logic        speed_q;
  logic        run;
  logic        speed_chg;
  logic        tick;
  logic [31:0] div_last;
  logic [7:0]  dim_cur;
  logic [7:0]  dim_next;
  logic [7:0]  hour_next, min_next, sec_next, day_next, month_next;
  logic [15:0] year_next;

  assign run        = (state == RUN);
  assign speed_chg  = (sw_speed != speed_q);
  assign div_last   = sw_speed ? FAST_LAST : TICK_LAST;
  assign tick       = run && !speed_chg && (presc >= div_last);
  assign dim_cur    = days_in_month(month, year);
  assign edit_field = state;

  always_comb begin
    hour_next  = hour;
    min_next   = min;
    sec_next   = sec;
    day_next   = day;
    month_next = month;
    year_next  = year;
    if (tick) begin
      sec_next = bcd_up(sec, 8'h00, 8'h59);
      if (sec == 8'h59) begin
        min_next = bcd_up(min, 8'h00, 8'h59);
        if (min == 8'h59) begin
          hour_next = bcd_up(hour, 8'h00, 8'h23);
          if (hour == 8'h23) begin
            day_next = bcd_up(day, 8'h01, dim_cur);
            if (day >= dim_cur) begin
              month_next = bcd_up(month, 8'h01, 8'h12);
              if (month == 8'h12) year_next = year_up(year);
            end
          end
        end
      end
    end else if (!run && (inc_p ^ dec_p)) begin
      case (state)
        SET_HOUR:  hour_next  = inc_p ? bcd_up(hour, 8'h00, 8'h23) : bcd_dn(hour, 8'h00, 8'h23);
        SET_MIN:   min_next   = inc_p ? bcd_up(min, 8'h00, 8'h59)  : bcd_dn(min, 8'h00, 8'h59);
        SET_SEC:   sec_next   = inc_p ? bcd_up(sec, 8'h00, 8'h59)  : bcd_dn(sec, 8'h00, 8'h59);
        SET_DAY:   day_next   = inc_p ? bcd_up(day, 8'h01, dim_cur) : bcd_dn(day, 8'h01, dim_cur);
        SET_MONTH: month_next = inc_p ? bcd_up(month, 8'h01, 8'h12) : bcd_dn(month, 8'h01, 8'h12);
        SET_YEAR:  year_next  = inc_p ? year_up(year) : year_dn(year);
        default:   ;
      endcase
    end
    // A month or year change can leave the day beyond the new month's length.
    dim_next = days_in_month(month_next, year_next);
    if (day_next > dim_next) day_next = dim_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      hour      <= 8'h00;
      min       <= 8'h00;
      sec       <= 8'h00;
      day       <= 8'h01;
      month     <= 8'h01;
      year      <= RESET_YEAR;
      presc     <= 32'd0;
      speed_q   <= 1'b0;
      tick_out  <= 1'b0;
      blink     <= 1'b0;
      blink_cnt <= 32'd0;
    end else begin
      speed_q  <= sw_speed;
      tick_out <= tick;
      hour     <= hour_next;
      min      <= min_next;
      sec      <= sec_next;
      day      <= day_next;
      month    <= month_next;
      year     <= year_next;

      if (!run || speed_chg || tick) presc <= 32'd0;
      else                           presc <= presc + 32'd1;

      if (chg_p) state <= (state == SET_YEAR) ? RUN : state_t'(state + 3'd1);

      if (run || inc_p || dec_p) begin
        blink     <= 1'b0;
        blink_cnt <= 32'd0;
      end else if (blink_cnt >= BLINK_LAST) begin
        blink     <= ~blink;
        blink_cnt <= 32'd0;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
    end
  end

`ifdef TWELVE_HOUR_EN
  logic [4:0] h_bin;
  logic [4:0] h12_bin;

  always_comb begin
    h_bin = 5'(hour[7:4]) * 5'd10 + 5'(hour[3:0]);
    pm    = (h_bin >= 5'd12);
    if (h_bin == 5'd0)       h12_bin = 5'd12;
    else if (h_bin > 5'd12)  h12_bin = h_bin - 5'd12;
    else                     h12_bin = h_bin;
    if (h12_bin >= 5'd10) hour12 = {4'd1, 4'(h12_bin - 5'd10)};
    else                  hour12 = {4'd0, 4'(h12_bin)};
  end
`endif

endmodule

// File: tb/tb_rtc_calendar_edit.sv
// Directed bench for rtc_calendar_edit: tick counting, calendar rollovers, editing, clamping, repeat, blink, reset.
module tb_rtc_calendar_edit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sw_speed = 1'b0;
  logic        butt_change = 1'b1;
  logic        butt_increase = 1'b1;
  logic        butt_decrease = 1'b1;
  logic [7:0]  hour, min, sec, day, month;
  logic [15:0] year;
  logic [2:0]  edit_field;
  logic        blink, tick_out;
`ifdef TWELVE_HOUR_EN
  logic [7:0]  hour12;
  logic        pm;
`endif

  int checks = 0;
  int failures = 0;

  rtc_calendar_edit #(
    .TICK_DIV(1000), .FAST_DIV(10), .REPEAT_DELAY(20), .REPEAT_PERIOD(8),
    .BLINK_DIV(16), .RESET_YEAR(16'h2024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_speed(sw_speed),
    .butt_change(butt_change), .butt_increase(butt_increase), .butt_decrease(butt_decrease),
    .hour(hour), .min(min), .sec(sec), .day(day), .month(month), .year(year),
    .edit_field(edit_field), .blink(blink), .tick_out(tick_out)
`ifdef TWELVE_HOUR_EN
    , .hour12(hour12), .pm(pm)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    butt_change = 1'b1; butt_increase = 1'b1; butt_decrease = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  // mask bits: [0] change, [1] increase, [2] decrease
  task automatic press(input logic [2:0] m);
    if (m[0]) butt_change = 1'b0;
    if (m[1]) butt_increase = 1'b0;
    if (m[2]) butt_decrease = 1'b0;
    cyc(2);
    if (m[0]) butt_change = 1'b1;
    if (m[1]) butt_increase = 1'b1;
    if (m[2]) butt_decrease = 1'b1;
    cyc(3);
  endtask

  task automatic press_n(input logic [2:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic test_reset();
    sw_speed = 1'b0;
    do_reset();
    checks++;
    if ({hour, min, sec} !== 24'h000000) begin
      failures++; $display("FAIL reset_time got %h want 000000", {hour, min, sec});
    end else $display("ok reset_time");
    checks++;
    if ({day, month, year} !== 32'h0101_2024) begin
      failures++; $display("FAIL reset_date got %h want 01012024", {day, month, year});
    end else $display("ok reset_date");
    checks++;
    if ({edit_field, blink, tick_out} !== 5'b000_0_0) begin
      failures++; $display("FAIL reset_ctrl got %b want 00000", {edit_field, blink, tick_out});
    end else $display("ok reset_ctrl");
  endtask

  task automatic test_run_ticks();
    int n = 0;
    sw_speed = 1'b1;
    for (int i = 0; i < 605; i++) begin
      cyc(1);
      if (tick_out === 1'b1) n++;
    end
    checks++;
    if (n != 60) begin
      failures++; $display("FAIL tick_count got %0d want 60", n);
    end else $display("ok tick_count");
    checks++;
    if ({hour, min, sec} !== 24'h000100) begin
      failures++; $display("FAIL tick_time got %h want 000100", {hour, min, sec});
    end else $display("ok tick_time");
  endtask

  // Sets 23:59:59 on 28-02 of (2024 + up - down), returns to RUN and checks the rollover.
  task automatic test_feb_rollover(input string name, input int up, input int down,
                                   input logic [15:0] pre_year, input logic [31:0] exp_date);
    bit got = 1'b0;
    sw_speed = 1'b1;
    do_reset();
    press(3'b001); press(3'b100);
    press(3'b001); press(3'b100);
    press(3'b001); press(3'b100);
    press(3'b001); press_n(3'b010, 27);
    press(3'b001); press(3'b010);
    press(3'b001); press_n(3'b010, up); press_n(3'b100, down);
    checks++;
    if ({hour, min, sec, day, month, year} !== {24'h235959, 8'h28, 8'h02, pre_year}) begin
      failures++;
      $display("FAIL %s_preload got %h want %h", name, {hour, min, sec, day, month, year},
               {24'h235959, 8'h28, 8'h02, pre_year});
    end else $display("ok %s_preload", name);
    press(3'b001);
    for (int i = 0; i < 40 && !got; i++) begin
      cyc(1);
      if (tick_out === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL %s_tick got none want one within 40 cycles", name);
    end else $display("ok %s_tick", name);
    checks++;
    if ({hour, min, sec, day, month, year} !== {24'h000000, exp_date}) begin
      failures++;
      $display("FAIL %s_rollover got %h want %h", name, {hour, min, sec, day, month, year},
               {24'h000000, exp_date});
    end else $display("ok %s_rollover", name);
  endtask

  task automatic test_year_wrap();
    bit got = 1'b0;
    sw_speed = 1'b1;
    do_reset();
    press(3'b001); press(3'b100);
    press(3'b001); press(3'b100);
    press(3'b001); press(3'b100);
    press(3'b001); press_n(3'b010, 30);
    press(3'b001); press(3'b100);
    press(3'b001); press_n(3'b100, 2025);
    checks++;
    if ({hour, min, sec, day, month, year} !== 56'h235959_31_12_9999) begin
      failures++; $display("FAIL y9999_preload got %h want 23595931129999",
                           {hour, min, sec, day, month, year});
    end else $display("ok y9999_preload");
    press(3'b001);
    for (int i = 0; i < 40 && !got; i++) begin
      cyc(1);
      if (tick_out === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || ({hour, min, sec, day, month, year} !== 56'h000000_01_01_0000)) begin
      failures++; $display("FAIL y9999_rollover got %h tick=%0d want 00000001010000",
                           {hour, min, sec, day, month, year}, got);
    end else $display("ok y9999_rollover");
  endtask

  task automatic test_clamp();
    sw_speed = 1'b0;
    do_reset();
    press_n(3'b001, 5); press_n(3'b010, 2);
    press_n(3'b001, 6); press_n(3'b010, 30);
    press(3'b001); press(3'b010);
    checks++;
    if ({day, month, edit_field} !== {8'h30, 8'h04, 3'd5}) begin
      failures++; $display("FAIL clamp_april got day=%h month=%h field=%0d want 30 04 5",
                           day, month, edit_field);
    end else $display("ok clamp_april");
    do_reset();
    press_n(3'b001, 5); press(3'b010);
    press(3'b001); press(3'b100);
    press(3'b001); press_n(3'b001, 4); press(3'b100);
    checks++;
    if ({day, month, year, edit_field} !== {8'h28, 8'h02, 16'h2023, 3'd4}) begin
      failures++; $display("FAIL feb2023_dec got %h/%h/%h field=%0d want 28/02/2023 4",
                           day, month, year, edit_field);
    end else $display("ok feb2023_dec");
    press(3'b010);
    checks++;
    if (day !== 8'h01) begin
      failures++; $display("FAIL feb2023_inc_wrap got %h want 01", day);
    end else $display("ok feb2023_inc_wrap");
  endtask

  task automatic test_repeat();
    sw_speed = 1'b0;
    do_reset();
    press_n(3'b001, 2); press_n(3'b100, 2);
    checks++;
    if (min !== 8'h58) begin
      failures++; $display("FAIL repeat_start got %h want 58", min);
    end else $display("ok repeat_start");
    butt_increase = 1'b0;
    cyc(39);
    butt_increase = 1'b1;
    cyc(4);
    checks++;
    if ({hour, min, tick_out} !== {8'h00, 8'h02, 1'b0}) begin
      failures++; $display("FAIL repeat_hold got hour=%h min=%h tick=%b want 00 02 0",
                           hour, min, tick_out);
    end else $display("ok repeat_hold");
  endtask

  task automatic test_blink_and_edit();
    bit seen = 1'b0;
    bit lit = 1'b0;
    sw_speed = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (blink === 1'b1) lit = 1'b1;
    end
    checks++;
    if (lit) begin
      failures++; $display("FAIL blink_run got 1 want 0 throughout RUN");
    end else $display("ok blink_run");
    press(3'b001);
    for (int i = 0; i < 48 && !seen; i++) begin
      cyc(1);
      if (blink === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL blink_edit got 0 want toggling in SET_HOUR");
    end else $display("ok blink_edit");
    press(3'b010);
    lit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (blink === 1'b1) lit = 1'b1;
    end
    checks++;
    if (lit || hour !== 8'h01) begin
      failures++; $display("FAIL blink_hold got lit=%0d hour=%h want 0 01", lit, hour);
    end else $display("ok blink_hold");
    press(3'b110);
    checks++;
    if ({hour, edit_field} !== {8'h01, 3'd1}) begin
      failures++; $display("FAIL both_steps got hour=%h field=%0d want 01 1", hour, edit_field);
    end else $display("ok both_steps");
    press(3'b011);
    checks++;
    if ({hour, min, edit_field} !== {8'h02, 8'h00, 3'd2}) begin
      failures++; $display("FAIL step_then_advance got hour=%h min=%h field=%0d want 02 00 2",
                           hour, min, edit_field);
    end else $display("ok step_then_advance");
  endtask

  task automatic test_reset_mid_edit();
    sw_speed = 1'b0;
    do_reset();
    press_n(3'b001, 6);
    butt_decrease = 1'b0;
    cyc(4);
    checks++;
    if ({year, edit_field} !== {16'h2023, 3'd6}) begin
      failures++; $display("FAIL pre_reset_year got %h field=%0d want 2023 6", year, edit_field);
    end else $display("ok pre_reset_year");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hour, min, sec, day, month, year, edit_field, blink, tick_out} !==
        {24'h000000, 32'h0101_2024, 3'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL async_reset got %h want 0000000101202400",
                           {hour, min, sec, day, month, year, edit_field, blink, tick_out});
    end else $display("ok async_reset");
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    press(3'b001);
    cyc(40);
    checks++;
    if ({hour, edit_field} !== {8'h00, 3'd1}) begin
      failures++; $display("FAIL held_through_reset got hour=%h field=%0d want 00 1",
                           hour, edit_field);
    end else $display("ok held_through_reset");
    butt_decrease = 1'b1;
    cyc(3);
    press(3'b100);
    checks++;
    if (hour !== 8'h23) begin
      failures++; $display("FAIL fresh_press got %h want 23", hour);
    end else $display("ok fresh_press");
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_feb_rollover("y2024", 0, 0, 16'h2024, 32'h29_02_2024);
    test_feb_rollover("y2100", 76, 0, 16'h2100, 32'h01_03_2100);
    test_feb_rollover("y2000", 0, 24, 16'h2000, 32'h29_02_2000);
    test_year_wrap();
    test_clamp();
    test_repeat();
    test_blink_and_edit();
    test_reset_mid_edit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
